tcdm_bank_arb_varlat: RTL and testbench
=======================================

// Module: tcdm_bank_arb_varlat
// PURPOSE
// - Slave-side counterpart of the per-master variable-latency address decoder in the TCDM crossbar.
// - One instance per memory bank: round-robin arbitrates NumIn master requests onto the single bank port.
// - Records the granted master index in an in-order ID FIFO.
// - Routes each bank response (vld_i/rdata_i) back to the master that issued it.
// - Bank latency is variable but responses are in order; at most MaxOutstanding requests are in flight.
// PARAMETERS
// - NumIn          8   number of masters (>=1)
// - ReqDataWidth   32  request payload width (addr/wdata/be/wen bundled)
// - RespDataWidth  32  response payload width
// - MaxOutstanding 4   ID FIFO depth = max in-flight requests (>=1)
// - LogNumIn       NumIn>1 ? $clog2(NumIn) : 1   derived, do not override
// PORTS
// - clk_i    in   1                          clock, all state on rising edge
// - rst_i    in   1                          synchronous, active-high reset
// - req_i    in   NumIn                      per-master request
// - data_i   in   NumIn x ReqDataWidth       per-master payload
// - gnt_o    out  NumIn                      per-master grant (one-hot or zero)
// - vld_o    out  NumIn                      per-master response valid (one-hot or zero)
// - rdata_o  out  RespDataWidth              response data, broadcast to all masters
// - req_o    out  1                          request to bank
// - data_o   out  ReqDataWidth               payload of selected master
// - gnt_i    in   1                          bank grant
// - vld_i    in   1                          bank response valid
// - rdata_i  in   RespDataWidth              bank response data
// - err_o    out  1                          sticky: vld_i received with ID FIFO empty
// BEHAVIOUR
// - Reset: rr pointer=0, lock=0, FIFO empty (count=0), err_o=0.
//   - Outputs in reset cycle: gnt_o=0, vld_o=0, req_o=0.
// - Arbitration: winner = first i with req_i[i], scanning from rr pointer upward with wrap NumIn-1 -> 0.
//   - req_o = |req_i & !full; data_o = data_i[winner].
// - Lock: if req_o=1 and gnt_i=0, lock=1 and winner is held next cycle (no re-arbitration).
//   - Lock clears on handshake or when req_i[winner] drops.
// - Handshake: req_o & gnt_i, same cycle.
//   - gnt_o[winner]=1, all other gnt_o=0.
//   - push winner index into FIFO; rr pointer <= winner+1 (mod NumIn).
//   - gnt_o is combinational from gnt_i: zero added latency.
// - Response: when vld_i & !empty, vld_o[FIFO head]=1 and pop; rdata_o = rdata_i (pass-through, 0 cycles).
// - Full (count==MaxOutstanding): req_o=0, gnt_o=0, regardless of gnt_i.
//   - Same-cycle pop does NOT free a slot (no bypass); req_o reasserts the cycle after count drops.
// - Simultaneous push and pop: count unchanged, both pointers advance.
// - Empty + vld_i: vld_o=0, nothing popped, err_o <= 1 (held until rst_i).
// - Pointer wrap: FIFO read/write pointers wrap at MaxOutstanding (non-power-of-2 allowed).
// - Count width: $clog2(MaxOutstanding+1).
// - Reset mid-operation: in-flight IDs discarded.
//   - Late bank responses after reset with FIFO empty raise err_o; bank must be reset alongside.
// - NumIn==1: no arbitration; winner=0, rr pointer constant 0.
// STRUCTURE
// - tcdm_varlat_pkg: shared typedefs/functions.
//   - rr_next_idx(ptr, req) priority-scan function.
//   - clog2-safe width helper, reused by the decoder side.
// - Sub-module tcdm_id_fifo_varlat: DEPTH, WIDTH=LogNumIn.
//   - push/pop/full/empty/head; synchronous active-high reset; no bypass.
// - Top: rr pointer + lock registers, combinational winner select, muxes, err flag.
// TESTING
// - Rotation: NumIn=4, all req_i=1, gnt_i=1 every cycle, latency 1.
//   - gnt_o sequence 0001,0010,0100,1000,0001; vld_o follows one cycle later in the same order.
// - Lock: req_i=0110, gnt_i=0 for 3 cycles then 1.
//   - data_o fixed at data_i[1] throughout; gnt_o=0010 on cycle 4; next winner is 2.
// - Full: MaxOutstanding=4, gnt_i=1, vld_i=0.
//   - 4 grants, then req_o=0; one vld_i -> vld_o to first granted master; req_o=1 next cycle.
// - Push+pop: FIFO count=2, handshake and vld_i in same cycle.
//   - count stays 2; head advances; correct master gets vld_o.
// - Error: vld_i=1 with FIFO empty -> vld_o=0000, err_o=1 next cycle and stays 1 until rst_i.
// - Reset: reset with 3 in flight -> count=0, gnt_o/vld_o=0; next req_i=1000 granted with rr ptr=0 scan.

Source files
------------

// File: rtl/tcdm_varlat_pkg.sv
// Shared helpers for the TCDM variable-latency crossbar: width helper and
// the round-robin priority scan used by the bank-side arbiter.
package tcdm_varlat_pkg;

    localparam int unsigned MAX_IN = 256;
    localparam int unsigned IDX_W  = 8;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [MAX_IN-1:0] req_vec_t;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req at or above ptr, wrapping at num; returns ptr when none is set.
    function automatic idx_t rr_next_idx(input idx_t ptr, input req_vec_t req, input int unsigned num);
        idx_t        best;
        logic        found;
        int unsigned cand;
        best  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_IN; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= num) cand = cand - num;
            if (k < num && !found && req[cand[IDX_W-1:0]]) begin
                best  = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/tcdm_id_fifo_varlat.sv
// In-order ID FIFO holding the master index of each outstanding bank request.
module tcdm_id_fifo_varlat
    import tcdm_varlat_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = safe_clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // No bypass: a push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_bank_arb_varlat.sv
// Per-bank round-robin arbiter with request lock and in-order response routing
// for banks of variable (but in-order) latency.
module tcdm_bank_arb_varlat
    import tcdm_varlat_pkg::*;
#(
    parameter int unsigned NumIn          = 8,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned LogNumIn       = safe_clog2(NumIn)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]   data_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [RespDataWidth-1:0]             rdata_o,
    output logic                                 req_o,
    output logic [ReqDataWidth-1:0]              data_o,
    input  logic                                 gnt_i,
    input  logic                                 vld_i,
    input  logic [RespDataWidth-1:0]             rdata_i,
    output logic                                 err_o
);

    logic [LogNumIn-1:0] rr_q, rr_d;
    logic [LogNumIn-1:0] lock_idx_q, lock_idx_d;
    logic                lock_q, lock_d;
    logic                err_q, err_d;
    logic [LogNumIn-1:0] winner;
    logic [LogNumIn-1:0] head;
    logic                full, empty;
    logic                hs, pop;
    req_vec_t            req_ext;

    // A locked winner is held while it keeps requesting; otherwise scan from the rr pointer.
    always_comb begin
        req_ext              = '0;
        req_ext[NumIn-1:0]   = req_i;
        if (lock_q && req_i[lock_idx_q]) winner = lock_idx_q;
        else                             winner = LogNumIn'(rr_next_idx(IDX_W'(rr_q), req_ext, NumIn));
    end

    assign req_o   = (|req_i) & ~full & ~rst_i;
    assign hs      = req_o & gnt_i;
    assign pop     = vld_i & ~empty & ~rst_i;
    assign data_o  = data_i[winner];
    assign rdata_o = rdata_i;
    assign err_o   = err_q;

    always_comb begin
        gnt_o = '0;
        vld_o = '0;
        if (hs)  gnt_o[winner] = 1'b1;
        if (pop) vld_o[head]   = 1'b1;
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = req_o & ~gnt_i;
        lock_idx_d = lock_d ? winner : lock_idx_q;
        err_d      = err_q | (vld_i & empty);
        if (hs) rr_d = (winner == LogNumIn'(NumIn - 1)) ? '0 : winner + LogNumIn'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    tcdm_id_fifo_varlat #(
        .DEPTH (MaxOutstanding),
        .WIDTH (LogNumIn)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_tcdm_bank_arb_varlat.sv
// Directed and randomized bench for tcdm_bank_arb_varlat against a queue-based reference model.
module tb_tcdm_bank_arb_varlat;

    localparam int N   = 4;
    localparam int DEP = 4;

    logic              clk_i;
    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [N-1:0][31:0] data_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      vld_o;
    logic [31:0]       rdata_o;
    logic              req_o;
    logic [31:0]       data_o;
    logic              gnt_i;
    logic              vld_i;
    logic [31:0]       rdata_i;
    logic              err_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int m_rr      = 0;
    bit m_lock    = 0;
    int m_lockidx = 0;
    bit m_err     = 0;
    int m_q[$];

    tcdm_bank_arb_varlat #(
        .NumIn          (N),
        .ReqDataWidth   (32),
        .RespDataWidth  (32),
        .MaxOutstanding (DEP)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .vld_o   (vld_o),
        .rdata_o (rdata_o),
        .req_o   (req_o),
        .data_o  (data_o),
        .gnt_i   (gnt_i),
        .vld_i   (vld_i),
        .rdata_i (rdata_i),
        .err_o   (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_win(input logic [N-1:0] rq);
        if (m_lock && rq[m_lockidx]) return m_lockidx;
        for (int k = 0; k < N; k++) begin
            if (rq[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return m_rr;
    endfunction

    // One clock: drive at negedge, check 1ns later, advance the model on posedge.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic g, input logic v,
                       input string tag, input int xg = -1, input int xv = -1);
        int  win;
        bit  full, ereq, hs, pop;
        logic [N-1:0] eg, ev;
        rst_i = r; req_i = rq; gnt_i = g; vld_i = v;
        for (int i = 0; i < N; i++) data_i[i] = $urandom;
        rdata_i = $urandom;
        #1;
        full = (m_q.size() == DEP);
        win  = model_win(rq);
        ereq = (rq != 0) && !full && !r;
        hs   = ereq && g;
        pop  = v && (m_q.size() > 0) && !r;
        eg   = hs  ? N'(1 << win)     : '0;
        ev   = pop ? N'(1 << m_q[0])  : '0;
        chk({tag, ".req"}, 32'(req_o), 32'(ereq));
        chk({tag, ".gnt"}, 32'(gnt_o), 32'(eg));
        chk({tag, ".vld"}, 32'(vld_o), 32'(ev));
        chk({tag, ".rdata"}, rdata_o, rdata_i);
        chk({tag, ".err"}, 32'(err_o), 32'(m_err));
        if (ereq)    chk({tag, ".data"}, data_o, data_i[win]);
        if (xg >= 0) chk({tag, ".gnt_dir"}, 32'(gnt_o), 32'(xg));
        if (xv >= 0) chk({tag, ".vld_dir"}, 32'(vld_o), 32'(xv));
        @(posedge clk_i);
        if (r) begin
            m_rr = 0; m_lock = 0; m_lockidx = 0; m_err = 0;
            m_q.delete();
        end else begin
            if (v && m_q.size() == 0) m_err = 1;
            if (pop) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back(win);
                m_rr = (win + 1) % N;
            end
            m_lock    = ereq && !g;
            m_lockidx = win;
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; req_i = '0; gnt_i = 1'b0; vld_i = 1'b0; rdata_i = '0;
        for (int i = 0; i < N; i++) data_i[i] = '0;
        @(negedge clk_i);

        cyc(1, 4'hF, 1, 1, "reset", 0, 0);
        cyc(1, 4'hF, 1, 1, "reset", 0, 0);

        cyc(0, 4'hF, 1, 0, "rot", 1);
        cyc(0, 4'hF, 1, 1, "rot", 2, 1);
        cyc(0, 4'hF, 1, 1, "rot", 4, 2);
        cyc(0, 4'hF, 1, 1, "rot", 8, 4);
        cyc(0, 4'hF, 1, 1, "rot", 1, 8);
        cyc(0, 4'h0, 0, 1, "rot_drain", 0, 1);

        cyc(0, 4'b0110, 0, 0, "lock", 0);
        cyc(0, 4'b0110, 0, 0, "lock", 0);
        cyc(0, 4'b0110, 0, 0, "lock", 0);
        cyc(0, 4'b0110, 1, 0, "lock", 2);
        cyc(0, 4'b0110, 1, 0, "lock_next", 4);
        cyc(0, 4'h0, 0, 1, "lock_drain", 0, 2);
        cyc(0, 4'h0, 0, 1, "lock_drain", 0, 4);
        cyc(0, 4'b0010, 0, 0, "lock_hold", 0);
        cyc(0, 4'b0011, 1, 0, "lock_hold", 2);
        cyc(0, 4'h0, 0, 1, "lock_hold_drain", 0, 2);

        cyc(0, 4'hF, 1, 0, "full", 4);
        cyc(0, 4'hF, 1, 0, "full", 8);
        cyc(0, 4'hF, 1, 0, "full", 1);
        cyc(0, 4'hF, 1, 0, "full", 2);
        cyc(0, 4'hF, 1, 0, "full_block", 0);
        cyc(0, 4'hF, 1, 1, "full_nobypass", 0, 4);
        cyc(0, 4'hF, 1, 0, "full_reopen", 4);

        cyc(0, 4'h0, 0, 1, "pp_drain", 0, 8);
        cyc(0, 4'h0, 0, 1, "pp_drain", 0, 1);
        cyc(0, 4'hF, 1, 1, "pushpop", 8, 2);
        cyc(0, 4'hF, 1, 0, "pp_fill", 1);
        cyc(0, 4'hF, 1, 0, "pp_fill", 2);
        cyc(0, 4'hF, 1, 0, "pp_full", 0);
        cyc(0, 4'h0, 0, 1, "pp_out", 0, 4);
        cyc(0, 4'h0, 0, 1, "pp_out", 0, 8);
        cyc(0, 4'h0, 0, 1, "pp_out", 0, 1);
        cyc(0, 4'h0, 0, 1, "pp_out", 0, 2);

        cyc(0, 4'h0, 0, 1, "err_set", 0, 0);
        cyc(0, 4'h0, 0, 0, "err_hold");
        cyc(0, 4'hF, 1, 0, "err_hold");
        chk("err_sticky", 32'(err_o), 32'd1);

        cyc(0, 4'hF, 1, 0, "pre_rst");
        cyc(0, 4'hF, 1, 0, "pre_rst");
        cyc(1, 4'hF, 1, 1, "mid_rst", 0, 0);
        chk("err_cleared", 32'(err_o), 32'd0);
        cyc(0, 4'b1000, 1, 0, "post_rst", 8);
        cyc(0, 4'h0, 0, 1, "post_rst_resp", 0, 8);

        for (int t = 0; t < 400; t++) begin
            cyc(($urandom_range(63) == 0), N'($urandom), 1'($urandom_range(1)),
                ($urandom_range(2) != 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
